// File: rtl/router_fifo.sv
// router_fifo: per-destination packet FIFO of the 1x3 router.
// Entries carry a header tag bit so data_out can return to IDLE between packets.
// Macro ROUTER_FIFO_TRISTATE_EN: when defined, IDLE floats (z); otherwise IDLE is zero.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int PW = WIDTH - 1;
`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'b0}};
`endif

    logic [WIDTH:0]  mem [DEPTH];
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic [PW-1:0]   pkt_cnt;
    logic [WIDTH:0]  entry;
    logic            do_wr, do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign entry = mem[rd_ptr[ADDR_W-1:0]];

    // storage: cleared on hard reset only, a soft flush leaves contents in place
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!soft_rst && do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    // pointers, packet byte counter and registered read data
    always_ff @(posedge clk) begin
        if (!rst || soft_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            data_out <= IDLE;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (do_rd) begin
                rd_ptr   <= rd_ptr + (ADDR_W+1)'(1);
                data_out <= entry[WIDTH-1:0];
                pkt_cnt  <= entry[WIDTH] ? {1'b0, entry[WIDTH-1:2]} + PW'(1)
                          : (pkt_cnt != '0 ? pkt_cnt - PW'(1) : pkt_cnt);
            end else if (pkt_cnt == '0) begin
                data_out <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed and random checks of router_fifo against a queue-based model.
module tb_router_fifo;
    localparam int DEPTH = 16;
`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [7:0] IDLE = 8'bz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    logic       clk = 0, rst = 0, soft_rst = 0, wr_en = 0, rd_en = 0, lfd_state = 0;
    logic [7:0] data_in = 0, data_out;
    logic       full, empty;
    int         errors = 0, checks = 0;

    router_fifo #(.WIDTH(8), .DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .rd_en(rd_en),
        .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference model: queue of {tag,byte}, remaining packet bytes, expected data_out
    logic [8:0] q[$];
    logic [6:0] m_pc = 0;
    logic [7:0] m_do = IDLE;
    bit         armed = 0;

    always @(posedge clk) begin
        logic [8:0] e;
        bit rd, wr;
        armed = 1;
        if (!rst || soft_rst) begin
            q.delete();
            m_pc = 0;
            m_do = IDLE;
        end else begin
            rd = rd_en && q.size() != 0;
            wr = wr_en && q.size() != DEPTH;
            if (rd) begin
                e = q.pop_front();
                m_do = e[7:0];
                if (e[8]) m_pc = 7'(e[7:2]) + 7'd1;
                else if (m_pc != 0) m_pc = m_pc - 7'd1;
            end else if (m_pc == 0) begin
                m_do = IDLE;
            end
            if (wr) q.push_back({lfd_state, data_in});
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("empty", empty, 8'(q.size() == 0));
            chk("full", full, 8'(q.size() == DEPTH));
            chk("data_out", data_out, m_do);
        end
    end

    task automatic cyc(input logic w, input logic r, input logic l, input logic [7:0] d);
        wr_en = w; rd_en = r; lfd_state = l; data_in = d;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; lfd_state = 0;
    endtask

    initial begin
        logic [7:0] pk[5];
        pk = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
        // reset
        cyc(0, 0, 0, 0);
        chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_dout", data_out, IDLE);
        rst = 1;
        cyc(0, 0, 0, 0);
        chk("idle_empty", empty, 1); chk("idle_full", full, 0); chk("idle_dout", data_out, IDLE);
        // one packet
        cyc(1, 0, 1, pk[0]);
        for (int i = 1; i < 5; i++) cyc(1, 0, 0, pk[i]);
        for (int i = 0; i < 5; i++) begin cyc(0, 1, 0, 0); chk("pkt_rd", data_out, pk[i]); end
        cyc(0, 0, 0, 0);
        chk("pkt_idle", data_out, IDLE); chk("pkt_empty", empty, 1);
        // fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(i));
        chk("fill_full", full, 1);
        cyc(1, 0, 0, 8'hFF);
        chk("ovf_full", full, 1);
        for (int i = 0; i < 16; i++) begin cyc(0, 1, 0, 0); chk("fill_rd", data_out, 8'(i)); end
        chk("fill_empty", empty, 1);
        // full with simultaneous read and write
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h10 + i));
        cyc(1, 1, 0, 8'hFF);
        chk("rw_rd", data_out, 8'h10); chk("rw_full", full, 0);
        for (int i = 1; i < 16; i++) begin cyc(0, 1, 0, 0); chk("rw_rest", data_out, 8'(8'h10 + i)); end
        chk("rw_empty", empty, 1);
        // soft reset mid-packet
        cyc(1, 0, 1, 8'h08); cyc(1, 0, 0, 8'hB1); cyc(1, 0, 0, 8'hB2); cyc(1, 0, 0, 8'hB3);
        cyc(0, 1, 0, 0); chk("sr_hdr", data_out, 8'h08);
        cyc(0, 1, 0, 0); chk("sr_b1", data_out, 8'hB1);
        cyc(0, 1, 0, 0); chk("sr_b2", data_out, 8'hB2);
        soft_rst = 1; cyc(0, 0, 0, 0); soft_rst = 0;
        chk("sr_empty", empty, 1); chk("sr_dout", data_out, IDLE);
        cyc(1, 0, 1, 8'h04); cyc(1, 0, 0, 8'hC1); cyc(1, 0, 0, 8'hC2);
        cyc(0, 1, 0, 0); chk("sr2_hdr", data_out, 8'h04);
        cyc(0, 1, 0, 0); chk("sr2_c1", data_out, 8'hC1);
        cyc(0, 1, 0, 0); chk("sr2_c2", data_out, 8'hC2);
        cyc(0, 0, 0, 0); chk("sr2_idle", data_out, IDLE);
        // pointer wrap
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin cyc(0, 1, 0, 0); chk("wrap_pre", data_out, 8'(8'h20 + i)); end
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h40 + i));
        chk("wrap_full", full, 1);
        for (int i = 0; i < 16; i++) begin cyc(0, 1, 0, 0); chk("wrap_rd", data_out, 8'(8'h40 + i)); end
        chk("wrap_empty", empty, 1);
        // length-63 header: count of 64 must not wrap to zero, so data_out holds
        cyc(1, 0, 1, 8'hFC); cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 0); chk("len63_hold", data_out, 8'hFC); end
        rst = 0; cyc(0, 0, 0, 0); rst = 1;
        chk("len63_rst", data_out, IDLE);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rst      = $urandom_range(0, 299) != 0;
            soft_rst = $urandom_range(0, 99) == 0;
            if (n < 2000) cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
            else          cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, 8'($urandom));
        end
        rst = 1; soft_rst = 0;
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
